// File: rtl/out_port_arbiter.sv
// rtl/out_port_arbiter.sv - round-robin wormhole allocator for one router output port
module out_port_arbiter #(
    parameter int             NUM_IN  = 5,
    parameter int             PW      = 3,
    parameter logic [PW-1:0]  PORT_ID = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_IN-1:0]    req_valid,
    input  logic [NUM_IN*PW-1:0] req_port,
    input  logic [NUM_IN-1:0]    flit_valid,
    input  logic [NUM_IN-1:0]    flit_tail,
    input  logic                 out_ready,
    output logic [NUM_IN-1:0]    grant,
    output logic [2:0]           grant_idx,
    output logic                 locked,
    output logic                 xfer
);

    // Route code meaning "no route"; never matches even if PORT_ID collides with it.
    localparam logic [PW-1:0] EMPTY = '1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [2:0]          rr_ptr;
    logic [NUM_IN-1:0]   act;
    logic                found;
    logic [2:0]          pick;
    logic [2:0]          nxt_ptr;
    logic                sel_valid;
    logic                sel_tail;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_act
        assign act[i] = req_valid[i]
                     && (req_port[i*PW +: PW] == PORT_ID)
                     && (req_port[i*PW +: PW] != EMPTY);
    end

    // First active input at or after rr_ptr, wrapping at NUM_IN-1.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        for (int k = 0; k < NUM_IN; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && act[idx]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    assign nxt_ptr = (pick == 3'(NUM_IN - 1)) ? 3'd0 : pick + 3'd1;

    // grant is one-hot on grant_idx, so masking selects the holder's flit flags.
    assign sel_valid = |(flit_valid & grant);
    assign sel_tail  = |(flit_tail & grant);
    assign xfer      = en && (state == LOCKED) && sel_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= 3'd0;
            locked    <= 1'b0;
            rr_ptr    <= 3'd0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= LOCKED;
                        grant     <= NUM_IN'(1) << pick;
                        grant_idx <= pick;
                        locked    <= 1'b1;
                        rr_ptr    <= nxt_ptr;
                    end
                end
                LOCKED: begin
                    if (xfer && sel_tail) begin
                        state     <= IDLE;
                        grant     <= '0;
                        grant_idx <= 3'd0;
                        locked    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    grant_idx <= 3'd0;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_arbiter.sv
// tb/tb_out_port_arbiter.sv - directed self-checking bench for out_port_arbiter
module tb_out_port_arbiter;

    localparam int            NUM_IN  = 5;
    localparam int            PW      = 3;
    localparam logic [2:0]    PID     = 3'd0;
    localparam logic [2:0]    OTHER   = 3'd2;
    localparam logic [2:0]    EMPTY   = 3'd7;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [NUM_IN-1:0]    req_valid;
    logic [NUM_IN*PW-1:0] req_port;
    logic [NUM_IN-1:0]    flit_valid;
    logic [NUM_IN-1:0]    flit_tail;
    logic                 out_ready;
    logic [NUM_IN-1:0]    grant;
    logic [2:0]           grant_idx;
    logic                 locked;
    logic                 xfer;

    int n_assert = 0;
    int n_fail   = 0;

    out_port_arbiter #(.NUM_IN(NUM_IN), .PW(PW), .PORT_ID(PID)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_port(req_port),
        .flit_valid(flit_valid), .flit_tail(flit_tail), .out_ready(out_ready),
        .grant(grant), .grant_idx(grant_idx), .locked(locked), .xfer(xfer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] g, input logic [2:0] gi,
                           input logic lk);
        chk({tag, ".grant"},     32'(grant),     32'(g));
        chk({tag, ".grant_idx"}, 32'(grant_idx), 32'(gi));
        chk({tag, ".locked"},    32'(locked),    32'(lk));
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        req_valid  = 5'b10011;
        req_port   = '0;
        flit_valid = 5'b11111;
        flit_tail  = 5'b00000;
        out_ready  = 1'b1;

        // 1: reset with active requests pending
        tick();
        tick();
        chk_out("rst", 5'b00000, 3'd0, 1'b0);
        chk("rst.xfer", 32'(xfer), 32'd0);

        // 2: single 3-flit packet on input 2
        req_valid  = 5'b00100;
        flit_valid = 5'b00000;
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("single.grant", 5'b00100, 3'd2, 1'b1);
        chk("single.rr_ptr", 32'(dut.rr_ptr), 32'd3);
        req_valid  = 5'b00000;
        flit_valid = 5'b00100;
        for (int f = 0; f < 3; f++) begin
            flit_tail = (f == 2) ? 5'b00100 : 5'b00000;
            #1;
            chk("single.xfer", 32'(xfer), 32'd1);
            tick();
            if (f < 2) chk_out("single.hold", 5'b00100, 3'd2, 1'b1);
        end
        chk_out("single.release", 5'b00000, 3'd0, 1'b0);
        flit_valid = 5'b00000;
        flit_tail  = 5'b00000;
        #1;
        chk("single.idle_xfer", 32'(xfer), 32'd0);

        // 3: round-robin among inputs 0,1,4 with single-flit packets
        rst_n     = 1'b0;
        req_valid = 5'b10011;
        tick();
        tick();
        rst_n = 1'b1;
        begin
            logic [2:0] order [4];
            order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd4; order[3] = 3'd0;
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_out("rr.grant", 5'(1) << order[k], order[k], 1'b1);
                flit_valid = grant;
                flit_tail  = grant;
                #1;
                chk("rr.xfer", 32'(xfer), 32'd1);
                tick();
                chk_out("rr.idle_gap", 5'b00000, 3'd0, 1'b0);
                flit_valid = 5'b00000;
                flit_tail  = 5'b00000;
            end
        end
        chk("rr.rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // 4: backpressure then bubbles while locked on input 1
        req_valid = 5'b00010;
        tick();
        chk_out("bp.grant", 5'b00010, 3'd1, 1'b1);
        chk("bp.rr_ptr", 32'(dut.rr_ptr), 32'd2);
        req_valid  = 5'b00000;
        flit_valid = 5'b00010;
        flit_tail  = 5'b00010;
        out_ready  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) begin
                out_ready  = 1'b1;
                flit_valid = 5'b00000;
            end
            #1;
            chk("bp.no_xfer", 32'(xfer), 32'd0);
            tick();
            chk_out("bp.held", 5'b00010, 3'd1, 1'b1);
        end
        flit_valid = 5'b00010;
        #1;
        chk("bp.xfer", 32'(xfer), 32'd1);
        tick();
        chk_out("bp.release", 5'b00000, 3'd0, 1'b0);
        flit_valid = 5'b00000;
        flit_tail  = 5'b00000;

        // 5: EMPTY code and foreign port filtered; en=0 freezes a locked port
        req_valid       = 5'b01001;
        req_port[0 +: 3] = OTHER;
        req_port[9 +: 3] = EMPTY;
        tick();
        tick();
        chk_out("filt.none", 5'b00000, 3'd0, 1'b0);
        chk("filt.rr_ptr", 32'(dut.rr_ptr), 32'd2);
        req_port[0 +: 3] = PID;
        tick();
        chk_out("filt.grant0", 5'b00001, 3'd0, 1'b1);
        req_valid  = 5'b00000;
        en         = 1'b0;
        flit_valid = 5'b00001;
        flit_tail  = 5'b00001;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("en.xfer_low", 32'(xfer), 32'd0);
            tick();
            chk_out("en.frozen", 5'b00001, 3'd0, 1'b1);
        end
        en = 1'b1;
        #1;
        chk("en.xfer", 32'(xfer), 32'd1);
        tick();
        chk_out("en.release", 5'b00000, 3'd0, 1'b0);
        flit_valid = 5'b00000;
        flit_tail  = 5'b00000;
        req_port   = '0;

        // 6: reset after the first of four flits
        req_valid = 5'b00100;
        tick();
        chk_out("mid.grant", 5'b00100, 3'd2, 1'b1);
        chk("mid.rr_ptr", 32'(dut.rr_ptr), 32'd3);
        req_valid  = 5'b00000;
        flit_valid = 5'b00100;
        #1;
        chk("mid.xfer", 32'(xfer), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk_out("mid.reset", 5'b00000, 3'd0, 1'b0);
        chk("mid.rr_ptr0", 32'(dut.rr_ptr), 32'd0);
        chk("mid.xfer0", 32'(xfer), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
